// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receive deframer with a one-deep valid/ready
// holding register. It reports framing errors and overruns.
module uart_rx_byte #(
    parameter int unsigned CLK_FREQUENCY = 50000000,
    parameter int unsigned BAUDRATE      = 230400,
    parameter int unsigned CLKS_PER_BIT  = CLK_FREQUENCY / BAUDRATE,
    parameter int unsigned HALF_BIT      = CLKS_PER_BIT / 2
) (
    input  logic       clki,
    input  logic       rstn,
    input  logic       RX,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                fe_q, fe_d;
    logic                ovr_q, ovr_d;
    logic                busy_q, busy_d;
    logic                rx_meta_q, rx_s_q;
    logic                tick;

    // Two-flop synchronizer for the asynchronous RX line; it idles high out of reset.
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, bit timing, shift register and output registers.
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign tick = (cnt_q == '0);

    // Next-state logic: mid-bit sampling, byte load and handshake bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ovr_d   = 1'b0;

        // Consumer takes the byte; a same-cycle load below re-asserts valid.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = CNT_W'(HALF_BIT - 1);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = CNT_W'(CLKS_PER_BIT - 1);
                    if (idx_q == IDX_W'(7)) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ovr_d   = valid_q && !ready;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BREAK: begin
                // A held-low line must return high before the next start bit is armed.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = fe_q;
    assign overrun     = ovr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte: directed frames, scoreboard checking of delivered bytes.
module tb_uart_rx_byte;

    localparam int unsigned CPB  = 217;
    localparam int unsigned HALF = 108;

    logic       clki = 1'b0;
    logic       rstn;
    logic       RX;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ovr_cnt  = 0;
    int pres_cnt = 0;
    int lat;
    int fall;
    int seen_busy;
    int fe0, ovr0, p0;

    logic [7:0] exp_q[$];
    logic       prev_valid  = 1'b0;
    logic       prev_accept = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    uart_rx_byte dut (
        .clki        (clki),
        .rstn        (rstn),
        .RX          (RX),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clki = ~clki;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clki);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
        RX = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            cyc(CPB);
        end
        RX = stop;
        cyc(CPB * stop_len);
        RX = 1'b1;
    endtask

    task automatic drain();
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
    endtask

    // Scoreboard monitor: every newly presented byte is popped and compared.
    always @(negedge clki) begin
        if (!rstn) begin
            prev_valid  = 1'b0;
            prev_accept = 1'b0;
            prev_data   = 8'h00;
        end else begin
            if (frame_error === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (valid === 1'b1 && (!prev_valid || prev_accept || data !== prev_data)) begin
                pres_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got byte 0x%0h, expected no byte", data);
                end else begin
                    check("sb_data", 32'(data), 32'(exp_q.pop_front()));
                end
            end
            prev_valid  = valid;
            prev_accept = valid & ready;
            prev_data   = data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RX    = 1'b1;
        ready = 1'b0;
        rstn  = 1'b0;
        #22;
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_fe", 32'(frame_error), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        cyc(2);
        rstn = 1'b1;
        cyc(5);

        // Basic byte with latency measurement from the first edge that registers RX low.
        exp_q.push_back(8'hA5);
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1, 1);
            begin
                int n;
                n = 0;
                while (n < 3000 && lat < 0) begin
                    @(posedge clki);
                    n++;
                    @(negedge clki);
                    if (valid === 1'b1) lat = n;
                end
            end
        join
        check_rng("basic_latency", lat, 2063, 2065);
        check("basic_valid", 32'(valid), 32'h1);
        check("basic_data", 32'(data), 32'hA5);
        drain();
        check("basic_valid_cleared", 32'(valid), 32'h0);

        // Back-to-back frames with the consumer always ready.
        ready = 1'b1;
        fe0 = fe_cnt; ovr0 = ovr_cnt; p0 = pres_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send_frame(8'h00, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);
        send_frame(8'h3C, 1'b1, 1);
        cyc(CPB);
        ready = 1'b0;
        check("b2b_count", 32'(pres_cnt - p0), 32'd3);
        check("b2b_no_fe", 32'(fe_cnt - fe0), 32'd0);
        check("b2b_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);

        // Glitch shorter than half a bit is rejected by the start re-check.
        cyc(2 * CPB);
        p0 = pres_cnt;
        fall = -1;
        seen_busy = 0;
        fork
            begin
                RX = 1'b0;
                cyc(50);
                RX = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (n < 400 && fall < 0) begin
                    @(posedge clki);
                    n++;
                    @(negedge clki);
                    if (busy === 1'b1) seen_busy = 1;
                    else if (seen_busy != 0) fall = n;
                end
            end
        join
        check("glitch_busy_seen", 32'(seen_busy), 32'd1);
        check_rng("glitch_busy_fall", fall, 1, HALF + 3);
        cyc(CPB);
        check("glitch_no_valid", 32'(pres_cnt - p0), 32'd0);
        check("glitch_idle", 32'(busy), 32'h0);

        // Framing error with the line held low, then recovery.
        fe0 = fe_cnt; p0 = pres_cnt;
        send_frame(8'h55, 1'b0, 3);
        cyc(CPB);
        check("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("fe_no_valid", 32'(pres_cnt - p0), 32'd0);
        check("fe_idle", 32'(busy), 32'h0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1);
        check("fe_recover_valid", 32'(valid), 32'h1);
        check("fe_recover_data", 32'(data), 32'h12);
        drain();

        // Overrun: second byte overwrites an unconsumed one.
        cyc(CPB);
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        check("ovr_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_data", 32'(data), 32'h22);
        drain();

        // Collision: ready lands on the exact stop-load cycle, so no overrun.
        cyc(CPB);
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1);
        exp_q.push_back(8'h44);
        fork
            send_frame(8'h44, 1'b1, 1);
            begin
                cyc(2063);
                ready = 1'b1;
                cyc(1);
                ready = 1'b0;
            end
        join
        check("coll_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);
        check("coll_valid", 32'(valid), 32'h1);
        check("coll_data", 32'(data), 32'h44);
        drain();

        // Reset in the middle of data bit 4 with a byte still held.
        cyc(CPB);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1);
        begin
            logic [7:0] pat;
            pat = 8'hC3;
            RX = 1'b0;
            cyc(CPB);
            for (int i = 0; i < 4; i++) begin
                RX = pat[i];
                cyc(CPB);
            end
            RX = pat[4];
            cyc(100);
        end
        check("pre_rst_busy", 32'(busy), 32'h1);
        rstn = 1'b0;
        #1;
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_fe", 32'(frame_error), 32'h0);
        check("mid_rst_ovr", 32'(overrun), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        RX = 1'b1;
        cyc(3);
        rstn = 1'b1;
        cyc(3);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1);
        check("post_rst_valid", 32'(valid), 32'h1);
        check("post_rst_data", 32'(data), 32'h7E);
        drain();

        cyc(10);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
